// File: rtl/machine_loader_pkg.sv
// Shared encodings for the machine state loader: stream header layout, op codes,
// controller states and halt-cause codes.
package machine_loader_pkg;

    typedef enum logic [1:0] {
        OP_REG     = 2'b00,
        OP_MEM     = 2'b01,
        OP_RUN     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        RUN,
        DONE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_ZERO_INST = 2'b01,
        CAUSE_BUDGET    = 2'b10,
        CAUSE_PROTOCOL  = 2'b11
    } cause_e;

    localparam int HDR_W       = 32;
    localparam int HDR_OP_LO   = 30;
    localparam int HDR_CNT_LO  = 24;
    localparam int HDR_CNT_W   = 6;
    localparam int HDR_BASE_W  = 24;

    function automatic op_e hdr_op(input logic [HDR_W-1:0] word);
        return op_e'(word[HDR_OP_LO +: 2]);
    endfunction

    // Header carries count-1, so a field value of 0 means a single payload word.
    function automatic logic [HDR_CNT_W-1:0] hdr_count_m1(input logic [HDR_W-1:0] word);
        return word[HDR_CNT_LO +: HDR_CNT_W];
    endfunction

    function automatic logic [HDR_BASE_W-1:0] hdr_base(input logic [HDR_W-1:0] word);
        return word[HDR_BASE_W-1:0];
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Counts machine cycles while running and raises a stop request on a zero
// instruction or when the cycle budget is exhausted; zero instruction wins a tie.
module run_watchdog
    import machine_loader_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16,
    parameter int CYCLE_BUDGET = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              active,
    input  logic [DATA_W-1:0] inst,
    output logic [CNT_W-1:0]  cycles,
    output logic              stop,
    output cause_e            cause
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CYCLE_BUDGET - 1);

    logic [CNT_W-1:0] cycles_reg;
    logic             zero_inst;
    logic             budget_hit;

    assign zero_inst  = (inst == '0);
    assign budget_hit = (cycles_reg == LAST_CYCLE);
    assign stop       = active && (zero_inst || budget_hit);
    assign cause      = zero_inst ? CAUSE_ZERO_INST : CAUSE_BUDGET;
    assign cycles     = cycles_reg;

    // The count freezes on the stop cycle so the reported value is the cycle that stopped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles_reg <= '0;
        end else if (clear) begin
            cycles_reg <= '0;
        end else if (active && !stop) begin
            cycles_reg <= cycles_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/machine_state_loader.sv
// Preloads the machine's register file and data memory from a header/payload word
// stream, launches the machine, and freezes it on halt or budget expiry.
module machine_state_loader
    import machine_loader_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RF_ADDR_W    = 5,
    parameter int MEM_ADDR_W   = 24,
    parameter int CYCLE_BUDGET = 64,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic [DATA_W-1:0]     inst,
    output logic                  machine_reset,
    output logic                  rf_we,
    output logic [RF_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  run_done,
    output logic [1:0]            halt_cause,
    output logic [CNT_W-1:0]      cycles
);

    state_e                  state_reg;
    op_e                     op_reg;
    logic [MEM_ADDR_W-1:0]   ptr_reg;
    logic [HDR_CNT_W-1:0]    rem_reg;
    logic                    cmd_ready_reg;
    logic                    machine_reset_reg;
    logic                    rf_we_reg;
    logic [RF_ADDR_W-1:0]    rf_waddr_reg;
    logic [DATA_W-1:0]       rf_wdata_reg;
    logic                    mem_we_reg;
    logic [MEM_ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]       mem_wdata_reg;
    logic                    run_done_reg;
    cause_e                  halt_cause_reg;

    logic                    accept;
    op_e                     cmd_op;
    logic [MEM_ADDR_W-1:0]   cmd_base;
    logic [RF_ADDR_W-1:0]    rf_ptr_next;
    logic [MEM_ADDR_W-1:0]   ptr_next;
    logic                    run_start;
    logic                    stop;
    cause_e                  stop_cause;

    assign accept    = cmd_valid && cmd_ready_reg;
    assign cmd_op    = hdr_op(cmd_data);
    assign run_start = (state_reg == HDR) && accept && (cmd_op == OP_RUN);

    // Register loads only use the low index bits of the base field.
    always_comb begin
        cmd_base = MEM_ADDR_W'(hdr_base(cmd_data));
        if (cmd_op == OP_REG) begin
            cmd_base = MEM_ADDR_W'(cmd_data[RF_ADDR_W-1:0]);
        end
    end

    // Register pointer wraps within the register file; memory pointer wraps naturally.
    always_comb begin
        rf_ptr_next = ptr_reg[RF_ADDR_W-1:0] + RF_ADDR_W'(1);
        ptr_next    = ptr_reg + MEM_ADDR_W'(1);
        if (op_reg == OP_REG) begin
            ptr_next = MEM_ADDR_W'(rf_ptr_next);
        end
    end

    run_watchdog #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .CYCLE_BUDGET (CYCLE_BUDGET)
    ) u_run_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (run_start),
        .active (state_reg == RUN),
        .inst   (inst),
        .cycles (cycles),
        .stop   (stop),
        .cause  (stop_cause)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= HDR;
            op_reg            <= OP_REG;
            ptr_reg           <= '0;
            rem_reg           <= '0;
            cmd_ready_reg     <= 1'b0;
            machine_reset_reg <= 1'b1;
            rf_we_reg         <= 1'b0;
            rf_waddr_reg      <= '0;
            rf_wdata_reg      <= '0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= '0;
            mem_wdata_reg     <= '0;
            run_done_reg      <= 1'b0;
            halt_cause_reg    <= CAUSE_NONE;
        end else begin
            rf_we_reg  <= 1'b0;
            mem_we_reg <= 1'b0;
            case (state_reg)
                HDR: begin
                    cmd_ready_reg <= 1'b1;
                    if (accept) begin
                        case (cmd_op)
                            OP_REG, OP_MEM: begin
                                state_reg <= DATA;
                                op_reg    <= cmd_op;
                                ptr_reg   <= cmd_base;
                                rem_reg   <= hdr_count_m1(cmd_data);
                            end
                            OP_RUN: begin
                                state_reg         <= RUN;
                                cmd_ready_reg     <= 1'b0;
                                machine_reset_reg <= 1'b0;
                            end
                            default: begin
                                state_reg      <= ERROR;
                                cmd_ready_reg  <= 1'b0;
                                run_done_reg   <= 1'b1;
                                halt_cause_reg <= CAUSE_PROTOCOL;
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (accept) begin
                        // r0 is hardwired: the word is consumed but never written.
                        if (op_reg == OP_REG) begin
                            rf_we_reg    <= (ptr_reg[RF_ADDR_W-1:0] != '0);
                            rf_waddr_reg <= ptr_reg[RF_ADDR_W-1:0];
                            rf_wdata_reg <= cmd_data;
                        end else begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= ptr_reg;
                            mem_wdata_reg <= cmd_data;
                        end
                        ptr_reg <= ptr_next;
                        if (rem_reg == '0) begin
                            state_reg <= HDR;
                        end else begin
                            rem_reg <= rem_reg - HDR_CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg         <= DONE;
                        machine_reset_reg <= 1'b1;
                        run_done_reg      <= 1'b1;
                        halt_cause_reg    <= stop_cause;
                    end
                end
                DONE, ERROR: begin
                    cmd_ready_reg     <= 1'b0;
                    machine_reset_reg <= 1'b1;
                    run_done_reg      <= 1'b1;
                end
                default: begin
                    state_reg <= HDR;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign machine_reset = machine_reset_reg;
    assign rf_we         = rf_we_reg;
    assign rf_waddr      = rf_waddr_reg;
    assign rf_wdata      = rf_wdata_reg;
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign run_done      = run_done_reg;
    assign halt_cause    = halt_cause_reg;

endmodule

// File: tb/tb_machine_state_loader.sv
// Directed bench for machine_state_loader: register/memory preload, run stop
// causes, protocol error and mid-load reset, with hand-computed expectations.
module tb_machine_state_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [31:0] inst;
    logic        machine_reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        run_done;
    logic [1:0]  halt_cause;
    logic [15:0] cycles;

    int checks = 0;
    int errors = 0;

    machine_state_loader dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .inst          (inst),
        .machine_reset (machine_reset),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .run_done      (run_done),
        .halt_cause    (halt_cause),
        .cycles        (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] word);
        cmd_valid = 1'b1;
        cmd_data  = word;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".machine_reset"}, 64'(machine_reset), 64'd1);
        check({tag, ".cmd_ready"},     64'(cmd_ready),     64'd0);
        check({tag, ".rf_we"},         64'(rf_we),         64'd0);
        check({tag, ".mem_we"},        64'(mem_we),        64'd0);
        check({tag, ".mem_addr"},      64'(mem_addr),      64'd0);
        check({tag, ".mem_wdata"},     64'(mem_wdata),     64'd0);
        check({tag, ".rf_waddr"},      64'(rf_waddr),      64'd0);
        check({tag, ".run_done"},      64'(run_done),      64'd0);
        check({tag, ".halt_cause"},    64'(halt_cause),    64'd0);
        check({tag, ".cycles"},        64'(cycles),        64'd0);
    endtask

    task automatic expect_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".rf_we"},  64'(rf_we),  64'(we));
        check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
        if (we) begin
            check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(a));
            check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(d));
        end
        $display("rf  %s: we=%0d addr=%0d data=0x%08h", tag, rf_we, rf_waddr, rf_wdata);
    endtask

    task automatic expect_mem(input string tag, input logic we, input logic [23:0] a, input logic [31:0] d);
        check({tag, ".mem_we"}, 64'(mem_we), 64'(we));
        check({tag, ".rf_we"},  64'(rf_we),  64'd0);
        if (we) begin
            check({tag, ".mem_addr"},  64'(mem_addr),  64'(a));
            check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(d));
        end
        $display("mem %s: we=%0d addr=0x%06h data=0x%08h", tag, mem_we, mem_addr, mem_wdata);
    endtask

    task automatic expect_stop(input string tag, input logic [1:0] cause, input logic [15:0] cyc);
        check({tag, ".run_done"},      64'(run_done),      64'd1);
        check({tag, ".halt_cause"},    64'(halt_cause),    64'(cause));
        check({tag, ".cycles"},        64'(cycles),        64'(cyc));
        check({tag, ".machine_reset"}, 64'(machine_reset), 64'd1);
        check({tag, ".cmd_ready"},     64'(cmd_ready),     64'd0);
        $display("run %s: done=%0d cause=%0d cycles=%0d", tag, run_done, halt_cause, cycles);
    endtask

    // Launch a run and step until the cycle counter shows n, checking it climbs from 0.
    task automatic run_to(input string tag, input int n);
        send(32'h8000_0000);
        check({tag, ".start_cycles"}, 64'(cycles),        64'd0);
        check({tag, ".start_mreset"}, 64'(machine_reset), 64'd0);
        check({tag, ".start_ready"},  64'(cmd_ready),     64'd0);
        for (int i = 0; i < n; i++) step();
        check({tag, ".pre_cycles"}, 64'(cycles),        64'(n));
        check({tag, ".pre_mreset"}, 64'(machine_reset), 64'd0);
        check({tag, ".pre_done"},   64'(run_done),      64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        inst      = 32'h0000_0013;

        // Reset state, then ready rises one cycle after release
        step();
        check_reset_state("reset");
        reset = 1'b1;
        step();
        check("hdr.cmd_ready", 64'(cmd_ready), 64'd1);

        // 1: REG base=5 count=3, back-to-back
        send(32'h0200_0005);
        expect_rf("t1.hdr", 1'b0, 5'd0, 32'd0);
        send(32'h0000_0000);
        expect_rf("t1.w0", 1'b1, 5'd5, 32'h0000_0000);
        send(32'h0000_0005);
        expect_rf("t1.w1", 1'b1, 5'd6, 32'h0000_0005);
        check("t1.mreset", 64'(machine_reset), 64'd1);
        send(32'h7FFF_FFFF);
        expect_rf("t1.w2", 1'b1, 5'd7, 32'h7FFF_FFFF);
        idle();
        expect_rf("t1.after", 1'b0, 5'd0, 32'd0);
        check("t1.ready", 64'(cmd_ready), 64'd1);

        // 2: MEM base=0x4000 count=4 with valid gaps
        send(32'h4300_4000);
        idle();
        expect_mem("t2.gap0", 1'b0, 24'd0, 32'd0);
        send(32'hA000_0000);
        expect_mem("t2.w0", 1'b1, 24'h004000, 32'hA000_0000);
        idle();
        expect_mem("t2.gap1", 1'b0, 24'd0, 32'd0);
        idle();
        expect_mem("t2.gap2", 1'b0, 24'd0, 32'd0);
        send(32'hA000_0001);
        expect_mem("t2.w1", 1'b1, 24'h004001, 32'hA000_0001);
        send(32'hA000_0002);
        expect_mem("t2.w2", 1'b1, 24'h004002, 32'hA000_0002);
        idle();
        expect_mem("t2.gap3", 1'b0, 24'd0, 32'd0);
        send(32'hA000_0003);
        expect_mem("t2.w3", 1'b1, 24'h004003, 32'hA000_0003);
        idle();
        expect_mem("t2.after", 1'b0, 24'd0, 32'd0);

        // 3: zero instruction at cycles==10
        run_to("t3", 10);
        inst = 32'd0;
        step();
        expect_stop("t3.stop", 2'b01, 16'd10);
        inst = 32'h0000_0013;
        step();
        expect_stop("t3.hold", 2'b01, 16'd10);

        // 4a: budget expiry
        do_reset();
        run_to("t4a", 63);
        step();
        expect_stop("t4a.stop", 2'b10, 16'd63);

        // 4b: zero inst on the last budget cycle takes priority
        do_reset();
        run_to("t4b", 63);
        inst = 32'd0;
        step();
        expect_stop("t4b.stop", 2'b01, 16'd63);
        inst = 32'h0000_0013;

        // 5: r31 then wrap to suppressed r0, then illegal header
        do_reset();
        send(32'h0100_001F);
        send(32'h0000_AAAA);
        expect_rf("t5.r31", 1'b1, 5'd31, 32'h0000_AAAA);
        send(32'h0000_BBBB);
        expect_rf("t5.r0", 1'b0, 5'd0, 32'd0);
        send(32'hC000_0000);
        check("t5.err_done",   64'(run_done),      64'd1);
        check("t5.err_cause",  64'(halt_cause),    64'd3);
        check("t5.err_mreset", 64'(machine_reset), 64'd1);
        check("t5.err_ready",  64'(cmd_ready),     64'd0);
        $display("err t5: done=%0d cause=%0d", run_done, halt_cause);
        idle();
        check("t5.err_hold", 64'(halt_cause), 64'd3);

        // 6: reset mid-load after 2 of 4 words
        do_reset();
        send(32'h4300_0010);
        send(32'h0000_1111);
        expect_mem("t6.w0", 1'b1, 24'h000010, 32'h0000_1111);
        send(32'h0000_2222);
        expect_mem("t6.w1", 1'b1, 24'h000011, 32'h0000_2222);
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 32'h0000_3333;
        step();
        check_reset_state("t6.rst");
        reset     = 1'b1;
        cmd_valid = 1'b0;
        step();
        check("t6.ready", 64'(cmd_ready), 64'd1);
        send(32'h8000_0000);
        check("t6.hdr_run_mreset", 64'(machine_reset), 64'd0);
        check("t6.hdr_run_ready",  64'(cmd_ready),     64'd0);
        check("t6.hdr_run_mem_we", 64'(mem_we),        64'd0);
        $display("hdr t6: machine_reset=%0d cmd_ready=%0d", machine_reset, cmd_ready);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
